// File: rtl/usb_rx_cdl.sv
// Full-speed USB receive front end: line synchroniser, bit-clock recovery, NRZI
// decode, bit unstuffing, SYNC/PID/EOP framing, and byte strobes to the packet buffer.
module usb_rx_cdl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [7:0] rx_data,
    output logic       store_rx_data,
    output logic [3:0] rx_pid,
    output logic       rx_pid_valid,
    output logic       rx_transfer_active,
    output logic       rx_packet_done,
    output logic       rx_error
);
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_MID  = PW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {SYM_SE0 = 2'b00, SYM_J = 2'b01, SYM_K = 2'b10} sym_t;
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, ERR_WAIT} state_t;

    logic [SYNC_STAGES-1:0] dp_sync_reg;
    logic [SYNC_STAGES-1:0] dm_sync_reg;
    sym_t          cur_sym;
    sym_t          prev_sym_reg;
    sym_t          last_sample_reg, last_sample_next;
    logic [PW-1:0] phase_reg, phase_next;
    state_t        state_reg, state_next;
    logic [2:0]    ones_reg, ones_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic [3:0]    pid_reg, pid_next;
    logic          eop_se0_reg, eop_se0_next;
    logic          wait_se0_reg, wait_se0_next;
    logic          store_reg, store_next;
    logic          pid_valid_reg, pid_valid_next;
    logic          active_reg, active_next;
    logic          done_reg, done_next;
    logic          error_reg, error_next;
    logic          line_dp, line_dm, is_se0, line_edge, sample, bit_val;
    logic [7:0]    new_byte;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync_reg <= '1;
            dm_sync_reg <= '0;
        end else begin
            dp_sync_reg[0] <= dplus_in;
            dm_sync_reg[0] <= dminus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dp_sync_reg[i] <= dp_sync_reg[i-1];
                dm_sync_reg[i] <= dm_sync_reg[i-1];
            end
        end
    end

    assign line_dp = dp_sync_reg[SYNC_STAGES-1];
    assign line_dm = dm_sync_reg[SYNC_STAGES-1];

    // Both lines equal (including the illegal 1,1) counts as SE0.
    always_comb begin
        if (line_dp == line_dm)
            cur_sym = SYM_SE0;
        else if (line_dp)
            cur_sym = SYM_J;
        else
            cur_sym = SYM_K;
    end

    assign is_se0    = (cur_sym == SYM_SE0);
    assign line_edge = (cur_sym != prev_sym_reg) && (cur_sym != SYM_SE0) && (prev_sym_reg != SYM_SE0);
    assign phase_next = (line_edge || phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
    assign sample    = (phase_reg == PHASE_MID);
    assign bit_val   = (cur_sym == last_sample_reg);
    assign new_byte  = {bit_val, shift_reg[7:1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_sym_reg    <= SYM_J;
            last_sample_reg <= SYM_J;
            phase_reg       <= '0;
            state_reg       <= IDLE;
            ones_reg        <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            rx_data_reg     <= '0;
            pid_reg         <= '0;
            eop_se0_reg     <= 1'b0;
            wait_se0_reg    <= 1'b0;
            store_reg       <= 1'b0;
            pid_valid_reg   <= 1'b0;
            active_reg      <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            prev_sym_reg    <= cur_sym;
            last_sample_reg <= last_sample_next;
            phase_reg       <= phase_next;
            state_reg       <= state_next;
            ones_reg        <= ones_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            rx_data_reg     <= rx_data_next;
            pid_reg         <= pid_next;
            eop_se0_reg     <= eop_se0_next;
            wait_se0_reg    <= wait_se0_next;
            store_reg       <= store_next;
            pid_valid_reg   <= pid_valid_next;
            active_reg      <= active_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_sample_next = last_sample_reg;
        ones_next        = ones_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        rx_data_next     = rx_data_reg;
        pid_next         = pid_reg;
        eop_se0_next     = eop_se0_reg;
        wait_se0_next    = wait_se0_reg;
        store_next       = 1'b0;
        pid_valid_next   = 1'b0;
        active_next      = active_reg;
        done_next        = 1'b0;
        error_next       = error_reg;

        if (sample) begin
            last_sample_next = cur_sym;
            case (state_reg)
                IDLE: begin
                    // The first K is also the first SYNC bit, so it is shifted in here.
                    if (cur_sym == SYM_K) begin
                        state_next   = SYNC;
                        shift_next   = new_byte;
                        bit_cnt_next = 3'd1;
                        ones_next    = '0;
                    end
                end
                SYNC, PID, DATA: begin
                    if (is_se0) begin
                        if (state_reg == DATA) begin
                            state_next   = EOP;
                            eop_se0_next = 1'b0;
                            bit_cnt_next = '0;
                            if (bit_cnt_reg != 3'd0)
                                error_next = 1'b1;
                        end else begin
                            state_next    = ERR_WAIT;
                            wait_se0_next = 1'b1;
                            active_next   = 1'b0;
                            if (state_reg == PID)
                                error_next = 1'b1;
                        end
                    end else if (ones_reg == 3'd6 && bit_val) begin
                        state_next    = ERR_WAIT;
                        wait_se0_next = 1'b0;
                        active_next   = 1'b0;
                        error_next    = 1'b1;
                    end else if (ones_reg == 3'd6) begin
                        ones_next = '0;
                    end else begin
                        ones_next    = bit_val ? ones_reg + 3'd1 : 3'd0;
                        shift_next   = new_byte;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (state_reg == SYNC) begin
                                if (new_byte == 8'h80) begin
                                    state_next  = PID;
                                    active_next = 1'b1;
                                    error_next  = 1'b0;
                                end else begin
                                    state_next    = ERR_WAIT;
                                    wait_se0_next = 1'b0;
                                end
                            end else if (state_reg == PID) begin
                                if (new_byte[7:4] == ~new_byte[3:0]) begin
                                    state_next     = DATA;
                                    pid_next       = new_byte[3:0];
                                    pid_valid_next = 1'b1;
                                end else begin
                                    state_next    = ERR_WAIT;
                                    wait_se0_next = 1'b0;
                                    active_next   = 1'b0;
                                    error_next    = 1'b1;
                                end
                            end else begin
                                rx_data_next = new_byte;
                                store_next   = 1'b1;
                            end
                        end
                    end
                end
                EOP: begin
                    if (!eop_se0_reg && is_se0) begin
                        eop_se0_next = 1'b1;
                    end else if (eop_se0_reg && cur_sym == SYM_J) begin
                        state_next  = IDLE;
                        active_next = 1'b0;
                        done_next   = !error_reg;
                    end else begin
                        state_next    = ERR_WAIT;
                        wait_se0_next = is_se0;
                        active_next   = 1'b0;
                        error_next    = 1'b1;
                    end
                end
                ERR_WAIT: begin
                    if (is_se0) begin
                        wait_se0_next = 1'b1;
                    end else if (cur_sym == SYM_J && wait_se0_reg) begin
                        state_next    = IDLE;
                        wait_se0_next = 1'b0;
                    end else if (cur_sym == SYM_K) begin
                        wait_se0_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign rx_data            = rx_data_reg;
    assign store_rx_data      = store_reg;
    assign rx_pid             = pid_reg;
    assign rx_pid_valid       = pid_valid_reg;
    assign rx_transfer_active = active_reg;
    assign rx_packet_done     = done_reg;
    assign rx_error           = error_reg;
endmodule

// File: tb/tb_usb_rx_cdl.sv
// Self-checking bench for usb_rx_cdl: packets are built from bytes (stuffing + NRZI),
// driven bit-by-bit, and the decoded strobes are compared against packet-level expectations.
module tb_usb_rx_cdl;
    localparam int CPB = 8;
    localparam logic [1:0] L_J   = 2'b10;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dplus_in;
    logic       dminus_in;
    logic [7:0] rx_data;
    logic       store_rx_data;
    logic [3:0] rx_pid;
    logic       rx_pid_valid;
    logic       rx_transfer_active;
    logic       rx_packet_done;
    logic       rx_error;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_bytes[$];
    int         pid_valid_cnt = 0;
    int         done_cnt = 0;

    logic       bits_q[$];
    logic [1:0] syms[$];
    logic [7:0] data_q[$];
    int         ones_run;
    logic [3:0] exp_pid;

    usb_rx_cdl #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .dplus_in(dplus_in),
        .dminus_in(dminus_in),
        .rx_data(rx_data),
        .store_rx_data(store_rx_data),
        .rx_pid(rx_pid),
        .rx_pid_valid(rx_pid_valid),
        .rx_transfer_active(rx_transfer_active),
        .rx_packet_done(rx_packet_done),
        .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (store_rx_data) got_bytes.push_back(rx_data);
        if (rx_pid_valid) pid_valid_cnt++;
        if (rx_packet_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_bit(input logic b, input logic stuff);
        bits_q.push_back(b);
        ones_run = b ? ones_run + 1 : 0;
        if (stuff && ones_run == 6) begin
            bits_q.push_back(1'b0);
            ones_run = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] v, input logic stuff);
        for (int i = 0; i < 8; i++) push_bit(v[i], stuff);
    endtask

    task automatic build_syms(input logic [7:0] pid_byte, input logic stuff_err);
        logic [1:0] level;
        bits_q.delete();
        syms.delete();
        ones_run = 0;
        push_byte(8'h80, 1'b1);
        push_byte(pid_byte, 1'b1);
        if (stuff_err) begin
            push_byte(data_q[0], 1'b1);
            for (int i = 0; i < 8; i++) push_bit(1'b1, 1'b0);
            push_byte(8'($urandom), 1'b0);
        end else begin
            foreach (data_q[i]) push_byte(data_q[i], 1'b1);
        end
        level = L_J;
        foreach (bits_q[i]) begin
            if (!bits_q[i]) level = (level == L_J) ? L_K : L_J;
            syms.push_back(level);
        end
        syms.push_back(L_SE0);
        syms.push_back(L_SE0);
        repeat (3) syms.push_back(L_J);
    endtask

    task automatic drive_syms(input int from, input int to);
        for (int i = from; i < to; i++) begin
            dplus_in  = syms[i][1];
            dminus_in = syms[i][0];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_packet(input logic [7:0] pid_byte, input logic stuff_err);
        logic       pid_ok;
        int         b0, v0, d0, nb;
        logic [7:0] exp_bytes[$];
        build_syms(pid_byte, stuff_err);
        pid_ok = (pid_byte[7:4] == ~pid_byte[3:0]);
        exp_bytes.delete();
        if (pid_ok) begin
            if (stuff_err) exp_bytes.push_back(data_q[0]);
            else foreach (data_q[i]) exp_bytes.push_back(data_q[i]);
        end
        b0 = got_bytes.size();
        v0 = pid_valid_cnt;
        d0 = done_cnt;
        drive_syms(0, 18);
        check("mid_active", 32'(rx_transfer_active), 32'(pid_ok));
        check("mid_error", 32'(rx_error), 32'(!pid_ok));
        drive_syms(18, syms.size());
        if (pid_ok) exp_pid = pid_byte[3:0];
        nb = got_bytes.size() - b0;
        check("pid_valid_cnt", 32'(pid_valid_cnt - v0), 32'(pid_ok));
        check("rx_pid", 32'(rx_pid), 32'(exp_pid));
        check("store_cnt", 32'(nb), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < nb; i++)
            check("rx_data", 32'(got_bytes[b0+i]), 32'(exp_bytes[i]));
        check("done_cnt", 32'(done_cnt - d0), 32'(pid_ok && !stuff_err));
        check("rx_error", 32'(rx_error), 32'(!pid_ok || stuff_err));
        check("active_end", 32'(rx_transfer_active), 32'd0);
        $display("pkt pid=%02h stuff_err=%0b bytes_exp=%0d bytes_got=%0d err=%0b", pid_byte, stuff_err, exp_bytes.size(), nb, rx_error);
    endtask

    initial begin
        logic [7:0] pid_byte;
        logic [3:0] p;
        int         r, n;

        n_rst = 1'b0;
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        exp_pid = 4'h0;
        repeat (4) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (20 * CPB) @(posedge clk);
        #1;
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_store", 32'(store_rx_data), 32'd0);
        check("rst_pid", 32'(rx_pid), 32'd0);
        check("rst_pid_valid", 32'(rx_pid_valid), 32'd0);
        check("rst_active", 32'(rx_transfer_active), 32'd0);
        check("rst_done", 32'(rx_packet_done), 32'd0);
        check("rst_error", 32'(rx_error), 32'd0);
        check("idle_strobes", 32'(got_bytes.size() + pid_valid_cnt + done_cnt), 32'd0);

        data_q.delete();
        run_packet(8'hD2, 1'b0);
        data_q = '{8'hA5, 8'hFF};
        run_packet(8'hC3, 1'b0);
        data_q.delete();
        run_packet(8'hC4, 1'b0);
        run_packet(8'hD2, 1'b0);
        data_q = '{8'h5A};
        run_packet(8'hC3, 1'b1);
        data_q.delete();
        run_packet(8'hD2, 1'b0);

        // Reset in the middle of the second data byte.
        data_q = '{8'h11, 8'h22, 8'h33};
        build_syms(8'hC3, 1'b0);
        drive_syms(0, 28);
        n_rst = 1'b0;
        #1;
        check("mrst_rx_data", 32'(rx_data), 32'd0);
        check("mrst_store", 32'(store_rx_data), 32'd0);
        check("mrst_pid", 32'(rx_pid), 32'd0);
        check("mrst_pid_valid", 32'(rx_pid_valid), 32'd0);
        check("mrst_active", 32'(rx_transfer_active), 32'd0);
        check("mrst_done", 32'(rx_packet_done), 32'd0);
        check("mrst_error", 32'(rx_error), 32'd0);
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        exp_pid = 4'h0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (5 * CPB) @(posedge clk);
        #1;
        data_q.delete();
        run_packet(8'hD2, 1'b0);

        for (int k = 0; k < 20; k++) begin
            r = $urandom_range(0, 9);
            data_q.delete();
            p = 4'($urandom);
            pid_byte = {~p, p};
            if (r < 6) begin
                n = $urandom_range(0, 4);
                for (int i = 0; i < n; i++)
                    data_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                run_packet(pid_byte, 1'b0);
            end else if (r < 8) begin
                do pid_byte = 8'($urandom); while (pid_byte[7:4] == ~pid_byte[3:0]);
                run_packet(pid_byte, 1'b0);
            end else begin
                data_q.push_back(8'($urandom));
                run_packet(pid_byte, 1'b1);
            end
            repeat ($urandom_range(0, 3) * CPB) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usb_rx_cdl.md
Name: usb_rx_cdl

Overview:
- Full-speed USB receive front end; counterpart of the ahb_tx_cdl transmit path.
- Oversamples D+/D-, resynchronises on edges, NRZI-decodes, unstuffs bits, detects SYNC/EOP and validates the PID.
- Emits decoded data bytes one per strobe to the shared packet buffer.
- Reports packet status to the AHB slave status/error registers.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period; must be at least 4.
- SYNC_STAGES, 2, flip-flop stages in the D+/D- input synchroniser.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- dplus_in  in  1  raw D+ line.
- dminus_in  in  1  raw D- line.
- rx_data  out  8  decoded byte, LSB received first.
- store_rx_data  out  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_pid  out  4  PID[3:0] of the current/last packet.
- rx_pid_valid  out  1  one-cycle strobe when a valid PID byte is accepted.
- rx_transfer_active  out  1  high from SYNC detection until EOP or abort.
- rx_packet_done  out  1  one-cycle strobe on a clean EOP after a valid PID.
- rx_error  out  1  sticky error flag; cleared by the next SYNC detection or by reset.

Behaviour:
- Reset:
  - All outputs are 0.
  - The line history is J (D+=1, D-=0).
  - The FSM is in IDLE.
  - Bit counters and the ones-counter are 0.
- Input path:
  - D+/D- pass through SYNC_STAGES flip-flops before any use.
  - Line symbols: J = (1,0), K = (0,1), SE0 = (0,0). (1,1) is treated as SE0.
- Bit timing:
  - A clock-phase counter runs 0..CLKS_PER_BIT-1.
  - The counter reloads to 0 on every synchronised J<->K transition.
  - The line is sampled when the counter equals CLKS_PER_BIT/2.
- NRZI: sampled symbol equal to the previous sample decodes as 1; a different symbol decodes as 0.
- Bit unstuffing:
  - A ones-counter increments on each decoded 1 and clears on each 0.
  - After six consecutive 1s, the next decoded bit is discarded if it is 0.
  - If that next bit is 1, it is a stuff error.
- FSM states: IDLE, SYNC, PID, DATA, EOP, ERR_WAIT.
  - IDLE -> SYNC on the first K sample.
  - SYNC:
    - Shift decoded bits until 8 are collected.
    - If they equal 8'b1000_0000 (decoded 00000001 LSB first, i.e. KJKJKJKK), go to PID, assert rx_transfer_active and clear rx_error.
    - Otherwise go to ERR_WAIT.
  - PID:
    - Collect 8 bits.
    - If byte[7:4] == ~byte[3:0], latch rx_pid = byte[3:0], pulse rx_pid_valid, go to DATA.
    - Otherwise set rx_error and go to ERR_WAIT.
  - DATA:
    - Each completed byte pulses store_rx_data one clock after its 8th unstuffed bit is sampled, with rx_data holding that byte.
    - An SE0 sample goes to EOP. If the bit count is not 0 at that point, it is a partial byte: set rx_error and discard the byte.
    - A stuff error sets rx_error and goes to ERR_WAIT.
  - EOP:
    - Requires a second consecutive SE0 sample, then a J sample.
    - On success: pulse rx_packet_done, drop rx_transfer_active, go to IDLE.
    - Any other sequence sets rx_error and goes to ERR_WAIT.
  - ERR_WAIT:
    - rx_transfer_active is 0.
    - Ignore the line until SE0 followed by a J sample, then go to IDLE.
- CRC bytes are not checked here; they are stored as ordinary data bytes. CRC checking is the buffer/host responsibility.
- Simultaneous events: an SE0 sample in the same cycle as byte completion stores the byte first, then enters EOP.
- Reset mid-packet: all state is cleared immediately, no strobes fire, and the next packet requires a full SYNC.
- Bytes per packet are unbounded. The byte counter is not exposed, so wrap-around is irrelevant.

Test Plan:
- After reset with the line at J for 20 bit times: all outputs are 0 and the FSM stays IDLE.
- SYNC + PID 0xD2 (ACK) + SE0,SE0,J: rx_pid_valid pulse with rx_pid=4'h2, zero store_rx_data pulses, one rx_packet_done, rx_error=0.
- SYNC + 0xC3 (DATA0) + 0xA5, 0xFF (stuffed 0 inserted after six 1s) + EOP: store_rx_data pulses twice with rx_data 0xA5 then 0xFF, then rx_packet_done.
- SYNC + PID 0xC4 (check nibble mismatch): rx_error=1, no rx_pid_valid, rx_transfer_active=0; the next good ACK packet clears rx_error at its SYNC.
- DATA0 packet with seven consecutive 1s (stuff violation): rx_error=1, no further store_rx_data, FSM recovers to IDLE after the next EOP.
- Assert n_rst in the middle of byte 2 of a DATA0 packet: all outputs are 0 immediately; the following complete ACK packet decodes correctly.
